// File: rtl/jac_control_unit_pkg.sv
// Shared constants and types for the Jac1-8 instruction sequencer: field widths, opcodes,
// ALU status bit positions and the sequencer FSM state type.
package jac_control_unit_pkg;

   localparam int unsigned DataWidth     = 8;
   localparam int unsigned NumOpCodeBits = 5;
   localparam int unsigned ParamBits     = 8;
   localparam int unsigned NumStatusBits = 3;
   localparam int unsigned NumRegs       = 8;
   localparam int unsigned RegIdxBits    = 3;
   localparam int unsigned InstrBits     = 16;

   // Instruction word layout: [15:11] opcode, [10:8] ra, [7:0] param
   localparam int unsigned OpMsb    = 15;
   localparam int unsigned OpLsb    = 11;
   localparam int unsigned RaMsb    = 10;
   localparam int unsigned RaLsb    = 8;
   localparam int unsigned ParamMsb = 7;

   localparam int unsigned StatC = 0;
   localparam int unsigned StatU = 1;
   localparam int unsigned StatZ = 2;

   localparam logic [NumOpCodeBits-1:0] OpNop  = 5'h00;
   localparam logic [NumOpCodeBits-1:0] OpAdd  = 5'h01;
   localparam logic [NumOpCodeBits-1:0] OpShr  = 5'h08;
   localparam logic [NumOpCodeBits-1:0] OpVal  = 5'h09;
   localparam logic [NumOpCodeBits-1:0] OpGoto = 5'h10;
   localparam logic [NumOpCodeBits-1:0] OpIfz  = 5'h11;
   localparam logic [NumOpCodeBits-1:0] OpIfnz = 5'h12;
   localparam logic [NumOpCodeBits-1:0] OpIfeq = 5'h13;
   localparam logic [NumOpCodeBits-1:0] OpIfst = 5'h14;
   localparam logic [NumOpCodeBits-1:0] OpIfgt = 5'h15;

   typedef enum logic [2:0] {
      StHalt,
      StFetch,
      StDecode,
      StExecute,
      StWriteback
   } state_e;

   function automatic logic is_reserved(input logic [NumOpCodeBits-1:0] op);
      return (op inside {[5'h0A:5'h0F], [5'h16:5'h1F]});
   endfunction

endpackage

// File: rtl/jac_control_unit_if.sv
// Instruction-memory fetch handshake and ALU_J issue/return signals of the Jac1-8 sequencer.
// master = sequencer side, slave = memory/ALU side.
interface jac_control_unit_if;
   import jac_control_unit_pkg::*;

   logic [ParamBits-1:0]     imem_addr;
   logic                     imem_rd;
   logic [InstrBits-1:0]     imem_data;
   logic                     imem_valid;
   logic [NumOpCodeBits-1:0] alu_opcode;
   logic [DataWidth-1:0]     alu_operand1;
   logic [DataWidth-1:0]     alu_operand2;
   logic [ParamBits-1:0]     alu_param;
   logic [DataWidth-1:0]     alu_result;
   logic [NumStatusBits-1:0] alu_status;

   modport master (
      output imem_addr, imem_rd, alu_opcode, alu_operand1, alu_operand2, alu_param,
      input  imem_data, imem_valid, alu_result, alu_status
   );

   modport slave (
      input  imem_addr, imem_rd, alu_opcode, alu_operand1, alu_operand2, alu_param,
      output imem_data, imem_valid, alu_result, alu_status
   );

endinterface

// File: rtl/jac_control_unit_regfile.sv
// 8x8 register file: two async read ports, an unsigned compare of port A against r0,
// one synchronous write port and a synchronous active-low clear.
module jac_control_unit_regfile
   import jac_control_unit_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [RegIdxBits-1:0] raddr_a_i,
   input  logic [RegIdxBits-1:0] raddr_b_i,
   output logic [DataWidth-1:0]  rdata_a_o,
   output logic [DataWidth-1:0]  rdata_b_o,
   output logic                  a_eq_r0_o,
   output logic                  a_lt_r0_o,
   output logic                  a_gt_r0_o,
   input  logic                  we_i,
   input  logic [RegIdxBits-1:0] waddr_i,
   input  logic [DataWidth-1:0]  wdata_i
);

   logic [DataWidth-1:0] regs_q [NumRegs];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];
   assign a_eq_r0_o = (rdata_a_o == regs_q[0]);
   assign a_lt_r0_o = (rdata_a_o <  regs_q[0]);
   assign a_gt_r0_o = (rdata_a_o >  regs_q[0]);

endmodule

// File: rtl/jac_control_unit.sv
// Jac1-8 instruction sequencer: fetch/decode/execute/writeback over the ALU_J interface.
// Optional JAC_ILLEGAL_TRAP_EN adds an 'illegal' output and halts on reserved opcodes.
module jac_control_unit
   import jac_control_unit_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     run,
   output logic                     halted,
   output logic [NumStatusBits-1:0] flags,
`ifdef JAC_ILLEGAL_TRAP_EN
   output logic                     illegal,
`endif
   jac_control_unit_if.master       bus
);

`ifdef JAC_ILLEGAL_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   state_e                   state_q;
   logic [ParamBits-1:0]     pc_q;
   logic [InstrBits-1:0]     ir_q;
   logic [DataWidth-1:0]     res_q;
   logic [NumStatusBits-1:0] stat_q;
   logic [NumStatusBits-1:0] flags_q;
   logic                     imem_rd_q;
   logic                     halted_q;
   logic [NumOpCodeBits-1:0] alu_opcode_q;
   logic [DataWidth-1:0]     alu_operand1_q;
   logic [DataWidth-1:0]     alu_operand2_q;
   logic [ParamBits-1:0]     alu_param_q;
`ifdef JAC_ILLEGAL_TRAP_EN
   logic                     illegal_q;
`endif

   logic [NumOpCodeBits-1:0] op;
   logic [RegIdxBits-1:0]    ra;
   logic [ParamBits-1:0]     param;
   logic [DataWidth-1:0]     rdata_a;
   logic [DataWidth-1:0]     rdata_b;
   logic                     a_eq_r0;
   logic                     a_lt_r0;
   logic                     a_gt_r0;
   logic                     is_arith;
   logic                     br_taken;
   logic                     trap;
   logic [ParamBits-1:0]     pc_next;
   logic                     rf_we;
   logic [DataWidth-1:0]     rf_wdata;

   assign op    = ir_q[OpMsb:OpLsb];
   assign ra    = ir_q[RaMsb:RaLsb];
   assign param = ir_q[ParamMsb:0];

   jac_control_unit_regfile u_regfile (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .raddr_a_i (ra),
      .raddr_b_i (param[RegIdxBits-1:0]),
      .rdata_a_o (rdata_a),
      .rdata_b_o (rdata_b),
      .a_eq_r0_o (a_eq_r0),
      .a_lt_r0_o (a_lt_r0),
      .a_gt_r0_o (a_gt_r0),
      .we_i      (rf_we),
      .waddr_i   (ra),
      .wdata_i   (rf_wdata)
   );

   // Branch resolution uses latched flags and live register compares at writeback
   always_comb begin
      br_taken = 1'b0;
      case (op)
         OpGoto:  br_taken = 1'b1;
         OpIfz:   br_taken = flags_q[StatZ];
         OpIfnz:  br_taken = ~flags_q[StatZ];
         OpIfeq:  br_taken = a_eq_r0;
         OpIfst:  br_taken = a_lt_r0;
         OpIfgt:  br_taken = a_gt_r0;
         default: br_taken = 1'b0;
      endcase
   end

   assign is_arith = (op >= OpAdd) && (op <= OpShr);
   assign trap     = TrapEn && is_reserved(op);
   assign pc_next  = br_taken ? param : pc_q + 8'd1;
   assign rf_we    = (state_q == StWriteback) && (is_arith || (op == OpVal));
   assign rf_wdata = (op == OpVal) ? param : res_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q        <= StHalt;
         pc_q           <= '0;
         ir_q           <= '0;
         res_q          <= '0;
         stat_q         <= '0;
         flags_q        <= '0;
         imem_rd_q      <= 1'b0;
         halted_q       <= 1'b1;
         alu_opcode_q   <= OpNop;
         alu_operand1_q <= '0;
         alu_operand2_q <= '0;
         alu_param_q    <= '0;
`ifdef JAC_ILLEGAL_TRAP_EN
         illegal_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StHalt: begin
               if (run) begin
                  state_q   <= StFetch;
                  imem_rd_q <= 1'b1;
                  halted_q  <= 1'b0;
               end
            end
            StFetch: begin
               if (bus.imem_valid) begin
                  ir_q      <= bus.imem_data;
                  imem_rd_q <= 1'b0;
                  state_q   <= StDecode;
               end
            end
            StDecode: begin
               alu_opcode_q   <= op;
               alu_operand1_q <= rdata_a;
               alu_operand2_q <= rdata_b;
               alu_param_q    <= param;
               state_q        <= StExecute;
            end
            StExecute: begin
               res_q          <= bus.alu_result;
               stat_q         <= bus.alu_status;
               alu_opcode_q   <= OpNop;
               alu_operand1_q <= '0;
               alu_operand2_q <= '0;
               alu_param_q    <= '0;
               state_q        <= StWriteback;
            end
            StWriteback: begin
               if (is_arith) begin
                  flags_q <= stat_q;
               end
               if (trap) begin
`ifdef JAC_ILLEGAL_TRAP_EN
                  illegal_q <= 1'b1;
`endif
                  state_q   <= StHalt;
                  halted_q  <= 1'b1;
               end else begin
                  pc_q <= pc_next;
                  if (run) begin
                     state_q   <= StFetch;
                     imem_rd_q <= 1'b1;
                  end else begin
                     state_q  <= StHalt;
                     halted_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StHalt;
         endcase
      end
   end

   assign halted           = halted_q;
   assign flags            = flags_q;
   assign bus.imem_addr    = pc_q;
   assign bus.imem_rd      = imem_rd_q;
   assign bus.alu_opcode   = alu_opcode_q;
   assign bus.alu_operand1 = alu_operand1_q;
   assign bus.alu_operand2 = alu_operand2_q;
   assign bus.alu_param    = alu_param_q;
`ifdef JAC_ILLEGAL_TRAP_EN
   assign illegal          = illegal_q;
`endif

endmodule

// File: tb/tb_jac_control_unit.sv
// Scoreboard bench for jac_control_unit: an architectural program model predicts every issued
// instruction; a negedge monitor checks fetches and ALU issue against the expected queue.
module tb_jac_control_unit;

`ifdef JAC_ILLEGAL_TRAP_EN
   localparam bit TrapBuild = 1'b1;
`else
   localparam bit TrapBuild = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       run = 1'b0;
   logic       halted;
   logic [2:0] flags;
`ifdef JAC_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   jac_control_unit_if bus ();

   jac_control_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run),
      .halted  (halted),
      .flags   (flags),
`ifdef JAC_ILLEGAL_TRAP_EN
      .illegal (illegal),
`endif
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ALU_J stand-in; returns {result, Z, U, C}
   function automatic logic [10:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic       c;
      logic       u;
      s = 9'd0;
      c = 1'b0;
      u = 1'b0;
      case (op)
         5'h01:   begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
         5'h02:   begin r = a - b; u = (a < b); end
         5'h03:   r = a & b;
         5'h04:   r = a | b;
         5'h05:   r = a ^ b;
         5'h06:   r = ~a;
         5'h07:   begin r = {a[6:0], 1'b0}; c = a[7]; end
         5'h08:   begin r = {1'b0, a[7:1]}; c = a[0]; end
         default: r = 8'h00;
      endcase
      return {r, (r == 8'h00), u, c};
   endfunction

   always_comb {bus.alu_result, bus.alu_status} =
      alu_fn(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);

   // Architectural reference model
   typedef struct {
      logic [7:0]  addr;
      logic [15:0] instr;
      logic [7:0]  op1;
      logic [7:0]  op2;
      logic [2:0]  flags;
   } exp_t;

   logic [15:0] mem [256];
   logic [7:0]  m_regs [8];
   logic [7:0]  m_pc;
   logic [2:0]  m_flags;
   exp_t        exp_q [$];

   task automatic model_reset();
      m_pc = 8'h00;
      m_flags = 3'b000;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      exp_q.delete();
   endtask

   task automatic model_step(output bit trapped);
      exp_t        e;
      logic [15:0] ins;
      logic [4:0]  op;
      logic [2:0]  ra;
      logic [7:0]  p;
      logic [10:0] a;
      bit          take;
      bit          rsv;
      ins = mem[m_pc];
      op = ins[15:11];
      ra = ins[10:8];
      p = ins[7:0];
      e.addr = m_pc;
      e.instr = ins;
      e.op1 = m_regs[ra];
      e.op2 = m_regs[p[2:0]];
      e.flags = m_flags;
      exp_q.push_back(e);
      trapped = 1'b0;
      take = 1'b0;
      rsv = (op >= 5'h0A && op <= 5'h0F) || (op >= 5'h16);
      if (op >= 5'h01 && op <= 5'h08) begin
         a = alu_fn(op, m_regs[ra], m_regs[p[2:0]]);
         m_regs[ra] = a[10:3];
         m_flags = a[2:0];
      end else if (op == 5'h09) begin
         m_regs[ra] = p;
      end
      case (op)
         5'h10: take = 1'b1;
         5'h11: take = m_flags[2];
         5'h12: take = !m_flags[2];
         5'h13: take = (m_regs[ra] == m_regs[0]);
         5'h14: take = (m_regs[ra] < m_regs[0]);
         5'h15: take = (m_regs[ra] > m_regs[0]);
         default: take = 1'b0;
      endcase
      if (rsv && TrapBuild) trapped = 1'b1;
      else m_pc = take ? p : m_pc + 8'd1;
   endtask

   // Instruction memory with configurable wait states and spurious valid pulses
   int min_wait = 0;
   int max_wait = 0;
   int wait_left = 0;

   always @(posedge clock) begin
      #1;
      if (bus.imem_rd && wait_left == 0) begin
         bus.imem_valid = 1'b1;
         bus.imem_data = mem[bus.imem_addr];
      end else begin
         bus.imem_valid = !bus.imem_rd && ($urandom_range(0, 3) == 0);
         bus.imem_data = 16'($urandom);
         if (bus.imem_rd) wait_left--;
         else wait_left = $urandom_range(max_wait, min_wait);
      end
   end

   // Monitor
   int         cyc = 0;
   int         exec_in = 0;
   int         n_exec = 0;
   int         last_acc = -1;
   int         lat_exp = 4;
   bit         lat_chk = 1'b0;
   exp_t       cur;
   logic [7:0] seen_addr [$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset_n) begin
         exec_in = 0;
      end else begin
         if (exec_in > 0) begin
            exec_in--;
            if (exec_in == 1) begin
               check("decode_alu_idle", {bus.alu_opcode, bus.alu_operand1, bus.alu_operand2,
                     bus.alu_param}, 29'd0);
            end else begin
               check("exec_opcode", bus.alu_opcode, cur.instr[15:11]);
               check("exec_operand1", bus.alu_operand1, cur.op1);
               check("exec_operand2", bus.alu_operand2, cur.op2);
               check("exec_param", bus.alu_param, cur.instr[7:0]);
               check("exec_flags", flags, cur.flags);
               n_exec++;
            end
         end
         if (bus.imem_rd) begin
            if (exp_q.size() == 0) begin
               check("unexpected_fetch", bus.imem_rd, 1'b0);
            end else begin
               check("fetch_addr", bus.imem_addr, exp_q[0].addr);
               if (bus.imem_valid) begin
                  cur = exp_q.pop_front();
                  seen_addr.push_back(bus.imem_addr);
                  exec_in = 2;
                  if (lat_chk && last_acc >= 0) check("latency", cyc - last_acc, lat_exp);
                  last_acc = cyc;
               end
            end
         end
      end
   end

   // Stimulus
   task automatic do_reset();
      reset_n = 1'b0;
      run = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic check_reset_state();
      check("rst_halted", halted, 1'b1);
      check("rst_imem_rd", bus.imem_rd, 1'b0);
      check("rst_flags", flags, 3'b000);
      check("rst_pc", bus.imem_addr, 8'h00);
      check("rst_alu_opcode", bus.alu_opcode, 5'h00);
`ifdef JAC_ILLEGAL_TRAP_EN
      check("rst_illegal", illegal, 1'b0);
`endif
   endtask

   task automatic run_prog(input int n);
      bit tr;
      int target;
      int lim;
      for (int i = 0; i < n; i++) begin
         model_step(tr);
         if (tr) break;
      end
      target = n_exec + exp_q.size();
      last_acc = -1;
      run = 1'b1;
      lim = 0;
      while (n_exec < target && lim < n * 12 + 50) begin
         @(negedge clock);
         lim++;
      end
      if (n_exec < target) check("exec_timeout", n_exec, target);
      run = 1'b0;
      lim = 0;
      while (!halted && lim < 20) begin
         @(negedge clock);
         lim++;
      end
      check("halted_after_run", halted, 1'b1);
      repeat (3) @(negedge clock);
      check("halt_imem_rd", bus.imem_rd, 1'b0);
      check("halt_pc", bus.imem_addr, m_pc);
      check("halt_flags", flags, m_flags);
   endtask

   task automatic load_directed();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = {5'h09, 3'd1, 8'h7F};
      mem[8'h01] = {5'h09, 3'd2, 8'h81};
      mem[8'h02] = {5'h01, 3'd1, 8'h02};
      mem[8'h03] = {5'h11, 3'd0, 8'h20};
      mem[8'h20] = {5'h12, 3'd0, 8'h40};
      mem[8'h21] = {5'h09, 3'd3, 8'h05};
      mem[8'h22] = {5'h09, 3'd0, 8'h09};
      mem[8'h23] = {5'h14, 3'd3, 8'h50};
      mem[8'h50] = {5'h10, 3'd0, 8'hFF};
      mem[8'hFF] = {5'h00, 3'd0, 8'h00};
   endtask

   task automatic gen_random_program();
      int         k;
      logic [4:0] op;
      for (int a = 0; a < 256; a++) begin
         k = $urandom_range(0, 15);
         op = (k < 10) ? 5'(k) : 5'(16 + k - 10);
         mem[a] = {op, 3'($urandom), 8'($urandom)};
      end
   endtask

   logic [7:0] dir_addr [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23,
                                 8'h50, 8'hFF, 8'h00};

   initial begin
      bit tr;
      do_reset();
      check_reset_state();

      // Directed program, zero-wait memory
      load_directed();
      min_wait = 0;
      max_wait = 0;
      lat_chk = 1'b1;
      lat_exp = 4;
      seen_addr.delete();
      run_prog(11);
      check("dir_count", seen_addr.size(), 11);
      for (int i = 0; i < 11; i++) check($sformatf("dir_addr%0d", i), seen_addr[i], dir_addr[i]);
      check("dir_flags_add", flags, 3'b101);
      check("dir_pc_end", bus.imem_addr, 8'h01);

      // Same program with a fixed 3-cycle fetch delay
      do_reset();
      min_wait = 3;
      max_wait = 3;
      lat_exp = 7;
      run_prog(4);
      check("wait_flags", flags, 3'b101);
      lat_chk = 1'b0;

      // Randomized programs, random wait states, restart with and without reset
      for (int r = 0; r < 4; r++) begin
         if (r == 2) do_reset();
         gen_random_program();
         min_wait = 0;
         max_wait = r;
         run_prog(120);
      end

      // Reset in the middle of execution abandons the in-flight work
      gen_random_program();
      min_wait = 2;
      max_wait = 3;
      for (int i = 0; i < 10; i++) model_step(tr);
      run = 1'b1;
      repeat (9) @(negedge clock);
      do_reset();
      check_reset_state();

      // Reserved opcode 0x1C
      min_wait = 0;
      max_wait = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = {5'h1C, 3'd2, 8'h33};
      run_prog(1);
      check("rsv_pc", bus.imem_addr, TrapBuild ? 32'h0 : 32'h1);
      check("rsv_halted", halted, 1'b1);
`ifdef JAC_ILLEGAL_TRAP_EN
      check("rsv_illegal", illegal, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
